// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and width helpers for the unified memory arbiter
package unified_mem_arbiter_pkg;

   // Arbiter FSM: idle, or serving the fetch port, or serving the data port
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_D_BUSY  = 2'd2
   } arb_state_e;

   // Defaults for the counter ranges; the top derives the real widths from its parameters
   localparam int TIMEOUT_DEF    = 15;
   localparam int STARVE_LIM_DEF = 3;

   // Bits needed to hold values 0..max_val (never less than one bit)
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int WAIT_W_DEF   = cnt_width(TIMEOUT_DEF);
   localparam int STARVE_W_DEF = cnt_width(STARVE_LIM_DEF);

endpackage

// File: rtl/unified_mem_arbiter_timer.sv
// rtl/unified_mem_arbiter_timer.sv - BUSY-phase wait counter that flags the timeout cycle
module mem_wait_timer
   import unified_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int W       = cnt_width(TIMEOUT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   // The count holds the number of unanswered BUSY cycles already seen, so the
   // TIMEOUT-th unanswered cycle is the one where the count still reads TIMEOUT-1.
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count_q, count_d;

   // Expiry is flagged during the unanswered cycle that brings the total to TIMEOUT
   always_comb begin
      expired_o = enable_i && (count_q == LAST);
      count_d   = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-ported memory between fetch and data ports
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 15,
   parameter int STARVE_LIM = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              err
);

   localparam int STARVE_W = cnt_width(STARVE_LIM);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

   arb_state_e          state_q, state_d;
   logic                if_valid_q, if_valid_d;
   logic                d_valid_q, d_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                err_q, err_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic                if_elig, d_elig;
   logic                grant_if, grant_d;
   logic                finish;
   logic [DATA_W-1:0]   fin_data;
   logic                timer_clear, timer_en, timer_expired;

   // A requester whose completion pulse is high this cycle is still holding
   // the old request, so it must not be taken as a fresh one.
   assign if_elig = if_req && !if_valid_q;
   assign d_elig  = d_req  && !d_valid_q;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (timer_clear),
      .enable_i  (timer_en),
      .expired_o (timer_expired)
   );

   // Arbitration, grant latching and completion (normal or timed-out)
   always_comb begin
      state_d     = state_q;
      if_valid_d  = 1'b0;
      d_valid_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
      grant_if    = 1'b0;
      grant_d     = 1'b0;
      finish      = 1'b0;
      fin_data    = '0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Data normally wins; a fetch that has waited out STARVE_LIM data grants goes first
            if (if_elig && (!d_elig || starve_q == STARVE_MAX)) begin
               grant_if = 1'b1;
            end else if (d_elig) begin
               grant_d = 1'b1;
            end
         end
         ST_IF_BUSY, ST_D_BUSY: begin
            timer_en = !mem_ready;
            if (mem_ready) begin
               finish   = 1'b1;
               fin_data = mem_we_q ? '0 : mem_rdata;
            end else if (timer_expired) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (grant_if) begin
         state_d     = ST_IF_BUSY;
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b0;
         mem_addr_d  = if_addr;
         mem_wdata_d = '0;
         timer_clear = 1'b1;
      end else if (grant_d) begin
         state_d     = ST_D_BUSY;
         mem_req_d   = 1'b1;
         mem_we_d    = d_we;
         mem_addr_d  = d_addr;
         mem_wdata_d = d_wdata;
         timer_clear = 1'b1;
      end

      if (finish) begin
         state_d   = ST_IDLE;
         mem_req_d = 1'b0;
         if (state_q == ST_IF_BUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = fin_data;
         end else begin
            d_valid_d = 1'b1;
            d_rdata_d = fin_data;
         end
      end
   end

   // Starvation tracking: data grants taken while a fetch is pending
   always_comb begin
      starve_d = starve_q;
      if (!if_req || grant_if) begin
         starve_d = '0;
      end else if (grant_d && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         if_valid_q  <= if_valid_d;
         d_valid_q   <= d_valid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign err       = err_q;

   // Stalls follow the live request so the pipeline freezes in the same cycle
   assign if_stall = if_req && !if_valid_q;
   assign d_stall  = d_req  && !d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for the unified memory arbiter
module tb_unified_mem_arbiter;

   localparam int TIMEOUT    = 15;
   localparam int STARVE_LIM = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, err;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: who owns the memory and the transaction's latched request
   int          m_owner;   // 0 none, 1 fetch, 2 data
   int          m_waited;
   int          m_starve;
   logic        m_if_valid, m_d_valid, m_err, m_we;
   logic [31:0] m_if_rdata, m_d_rdata, m_addr, m_wdata;

   always #5 clk = ~clk;

   unified_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .TIMEOUT    (TIMEOUT),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .if_stall  (if_stall),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .d_stall   (d_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err       (err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_waited = 0; m_starve = 0;
      m_if_valid = 1'b0; m_d_valid = 1'b0; m_err = 1'b0; m_we = 1'b0;
      m_if_rdata = '0; m_d_rdata = '0; m_addr = '0; m_wdata = '0;
   endtask

   // Advance the model by one clock using the inputs the DUT is about to sample
   task automatic model_update();
      logic        pv_if, pv_d, ei, ed, fin;
      logic [31:0] res;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pv_if = m_if_valid;
      pv_d  = m_d_valid;
      m_if_valid = 1'b0;
      m_d_valid  = 1'b0;
      if (m_owner == 0) begin
         ei = if_req && !pv_if;
         ed = d_req && !pv_d;
         if (ed && !(ei && m_starve == STARVE_LIM)) begin
            m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_waited = 0;
            m_starve = if_req ? ((m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM) : 0;
         end else if (ei) begin
            m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_waited = 0;
            m_starve = 0;
         end
      end else begin
         fin = 1'b0;
         res = '0;
         if (mem_ready) begin
            fin = 1'b1;
            res = m_we ? 32'h0 : mem_rdata;
         end else begin
            m_waited++;
            if (m_waited >= TIMEOUT) begin
               fin = 1'b1;
               m_err = 1'b1;
            end
         end
         if (fin) begin
            if (m_owner == 1) begin
               m_if_valid = 1'b1; m_if_rdata = res;
            end else begin
               m_d_valid = 1'b1; m_d_rdata = res;
            end
            m_owner = 0;
         end
      end
      if (!if_req) m_starve = 0;
   endtask

   task automatic check_outputs();
      chk("mem_req", mem_req, (m_owner != 0));
      chk("if_valid", if_valid, m_if_valid);
      chk("d_valid", d_valid, m_d_valid);
      chk("err", err, m_err);
      if (m_owner != 0) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", mem_we, m_we);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_if_valid) chk("if_rdata", if_rdata, m_if_rdata);
      if (m_d_valid) chk("d_rdata", d_rdata, m_d_rdata);
   endtask

   // One clock: check the combinational stalls, step the model, clock, check registered outputs
   task automatic tick();
      #1;
      chk("if_stall", if_stall, if_req & ~m_if_valid);
      chk("d_stall", d_stall, d_req & ~m_d_valid);
      model_update();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_if_valid"}, if_valid, 0);
      chk({tag, "_d_valid"}, d_valid, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   typedef struct {
      logic if_req;
      logic d_req;
      logic mem_ready;
      logic e_if_valid;
      logic e_d_valid;
      logic e_mem_req;
      logic e_mem_we;
   } vec_t;

   vec_t vecs[6];
   int   req_cycles;

   initial begin
      // Simultaneous fetch and load, zero-wait memory; each row: inputs of cycle i,
      // expected registered outputs in cycle i+1
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      model_reset();
      rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      tick();
      tick();
      chk_reset_values("por");
      rst_n = 1'b1;
      tick();

      // Table: data first, then fetch, requests during valid cycles ignored
      if_addr = 32'h40; d_addr = 32'h100; d_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if_req = vecs[i].if_req; d_req = vecs[i].d_req; mem_ready = vecs[i].mem_ready;
         mem_rdata = $urandom;
         tick();
         chk($sformatf("vec%0d_if_valid", i), if_valid, vecs[i].e_if_valid);
         chk($sformatf("vec%0d_d_valid", i), d_valid, vecs[i].e_d_valid);
         chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_mem_req);
         if (vecs[i].e_mem_req) chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_mem_we);
      end

      // Fetch only, zero-wait
      if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h2002000A;
      #1 chk("fetch_stall_c0", if_stall, 1);
      tick();
      chk("fetch_mem_req_c1", mem_req, 1);
      chk("fetch_mem_addr_c1", mem_addr, 32'h40);
      chk("fetch_stall_c1", if_stall, 1);
      tick();
      chk("fetch_valid_c2", if_valid, 1);
      chk("fetch_rdata_c2", if_rdata, 32'h2002000A);
      chk("fetch_stall_c2", if_stall, 0);
      if_req = 1'b0;
      tick();

      // Store with three wait cycles; requester inputs wander during BUSY
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
      tick();
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("store_we_c%0d", k), mem_we, 1);
         chk($sformatf("store_wdata_c%0d", k), mem_wdata, 32'hDEADBEEF);
         chk($sformatf("store_addr_c%0d", k), mem_addr, 32'h8);
         if (k == 1) begin
            d_addr = 32'hFFFF_0000; d_wdata = 32'h1234_5678; d_we = 1'b0;
         end
         mem_ready = (k == 4);
         mem_rdata = $urandom;
         tick();
      end
      chk("store_valid_c5", d_valid, 1);
      chk("store_rdata_c5", d_rdata, 0);
      d_req = 1'b0;
      tick();

      // Timeout on a load that never gets mem_ready
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; mem_ready = 1'b0;
      req_cycles = 0;
      tick();
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (mem_req) req_cycles++;
         tick();
      end
      chk("timeout_req_cycles", req_cycles, TIMEOUT);
      chk("timeout_mem_req", mem_req, 0);
      chk("timeout_d_valid", d_valid, 1);
      chk("timeout_rdata", d_rdata, 0);
      chk("timeout_err", err, 1);
      d_req = 1'b0;
      tick();
      tick();
      if_req = 1'b1; if_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      tick();
      chk("err_sticky_valid", if_valid, 1);
      chk("err_sticky", err, 1);
      if_req = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("err_cleared", err, 0);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a data access, then the held request is served
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; mem_ready = 1'b0;
      tick();
      tick();
      chk("midrst_busy", mem_req, 1);
      rst_n = 1'b0;
      tick();
      chk_reset_values("midrst");
      rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      chk("midrst_req_again", mem_req, 1);
      chk("midrst_addr_again", mem_addr, 32'h30);
      tick();
      chk("midrst_valid", d_valid, 1);
      chk("midrst_rdata", d_rdata, 32'hCAFE_0001);
      d_req = 1'b0;
      tick();

      // Randomised traffic against the model
      for (int c = 0; c < 600; c++) begin
         if (if_req) begin
            if (m_if_valid) begin
               if ($urandom_range(0, 1) == 0) if_req = 1'b0;
               else if_addr = $urandom;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
         end
         if (d_req) begin
            if (m_d_valid) begin
               if ($urandom_range(0, 1) == 0) d_req = 1'b0;
               else begin
                  d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
               end
            end
         end else if ($urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         mem_rdata = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch (IF) port and its data-access (MEM-stage) port. The block grants one requester at a time, issues one request per grant to the memory with a ready handshake, returns read data, and drives stall signals that freeze the pipeline while a requester waits. It sits between the PC/IF_ID fetch path and the EX_MEM/MEM_WB data path on one side and the memory on the other.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum BUSY cycles without mem_ready before abort; range 1..255
- STARVE_LIM, 3, consecutive data grants allowed while IF is pending before IF is forced ahead; range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  fetch waiting: if_req & ~if_valid
- d_req  in  1  data request; level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  one-cycle completion pulse for data
- d_stall  out  1  data waiting: d_req & ~d_valid
- mem_req  out  1  memory request, high for entire BUSY phase
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready
- mem_ready  in  1  memory completion, may be high in first BUSY cycle
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE: a requester is eligible if its req is high and its valid is not high this cycle (valid-cycle req is ignored, not a new request).
- Arbitration in IDLE: data wins over IF when both eligible, unless starve_cnt == STARVE_LIM, then IF wins. Only one eligible -> it wins. None -> stay IDLE.
- On grant: latch addr (and we/wdata for data; mem_we=0 for IF), go to X_BUSY, clear wait counter.
- starve_cnt: +1 on each data grant while if_req high; cleared on any IF grant or when if_req low; saturates at STARVE_LIM.
- X_BUSY: mem_req=1. On mem_ready: capture mem_rdata into X_rdata (stores capture 0), assert X_valid next cycle, go IDLE.
- Timeout: wait counter increments each BUSY cycle without mem_ready; on reaching TIMEOUT, drop mem_req, set err, pulse X_valid with X_rdata=0, go IDLE.
- mem_ready in IDLE is ignored.
- Reset (including mid-transaction): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=d_valid=0, if_rdata=d_rdata=0, starve_cnt=0, wait counter=0, err=0. In-flight access is abandoned; no valid pulse.

## Timing
- Zero-wait memory: req seen in IDLE at cycle N -> mem_req cycles N+1 -> valid at N+2. Minimum latency 2 cycles; back-to-back throughput one access per 2 cycles.
- k wait cycles (mem_ready at BUSY cycle k+1) -> valid at N+2+k.
- Simultaneous if_req/d_req at N: data valid N+2, IF granted at N+2, IF valid N+4 (zero-wait).
- All outputs except if_stall/d_stall are registered; stalls are combinational from req and registered valid.
- mem_addr/mem_we/mem_wdata stable for entire BUSY phase regardless of requester input changes.

## Structure
- Package unified_mem_arbiter_pkg: state enum (IDLE, IF_BUSY, D_BUSY), width constants for wait and starve counters derived from TIMEOUT/STARVE_LIM.
- One sub-module: mem_wait_timer (clear, enable, count, expired at TIMEOUT); the rest in one FSM module.

## Test plan
- if_req only, addr 0x40, mem_ready in first BUSY cycle, mem_rdata 0x2002000A -> if_valid at cycle 2, if_rdata 0x2002000A, if_stall high cycles 0-1.
- if_req and d_req (load 0x100) together, zero-wait -> data served first (d_valid cycle 2), IF valid cycle 4; mem_we 0 both.
- Store d_addr 0x8, d_wdata 0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata stable 4 BUSY cycles, d_valid cycle 5.
- Continuous d_req with if_req held, STARVE_LIM=3 -> exactly 3 data grants then IF grant; starve_cnt returns to 0.
- mem_ready never asserted, TIMEOUT=15 -> mem_req drops after 15 cycles, err=1, X_valid pulse with rdata 0; err stays until rst_n low.
- rst_n low during D_BUSY -> next cycle all outputs at reset values, no d_valid; following request served normally.
